// File: rtl/data_memory_hs.sv
// rtl/data_memory_hs.sv - byte-addressed data memory with valid/ready handshake, 1-cycle response (optional DMEM_MISALIGN_EN)
module data_memory_hs #(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic {IDLE, RESP} state_t;

  state_t          state;
  state_t          state_next;
  logic [7:0]      mem [DEPTH_BYTES];
  logic            accept;
  logic [2:0]      nbytes;
  logic [ADDR_W:0] last_addr;
  logic            in_range;
  logic            misaligned;
  logic            bad;
  logic [AW-1:0]   idx [4];
  logic [7:0]      rbyte [4];
  logic [31:0]     load_data;

  assign rsp_valid = (state == RESP);
  assign req_ready = !rsp_valid || rsp_ready;
  // Nothing is accepted while reset is held, so a request held across reset cannot write.
  assign accept    = rst && req_valid && req_ready;

  // Access width, range and alignment checks; the range check is done one bit wider so it cannot wrap.
  always_comb begin
    nbytes = 3'd1;
    case (req_size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      2'b10:   nbytes = 3'd4;
      default: nbytes = 3'd1;
    endcase
    last_addr = {1'b0, req_addr} + (ADDR_W+1)'(nbytes) - (ADDR_W+1)'(1);
    in_range  = last_addr < (ADDR_W+1)'(DEPTH_BYTES);
`ifdef DMEM_MISALIGN_EN
    misaligned = 1'b0;
`else
    misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                 ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`endif
    bad = (req_size == 2'b11) || !in_range || misaligned;
  end

  // Byte lanes: lane k addresses addr+k; only lanes below nbytes matter, and only when in range.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      idx[k]   = req_addr[AW-1:0] + AW'(k);
      rbyte[k] = mem[idx[k]];
    end
  end

  // Little-endian load assembly with sign/zero extension for byte and half.
  always_comb begin
    load_data = {rbyte[3], rbyte[2], rbyte[1], rbyte[0]};
    case (req_size)
      2'b00:   load_data = req_unsigned ? {24'b0, rbyte[0]} : {{24{rbyte[0][7]}}, rbyte[0]};
      2'b01:   load_data = req_unsigned ? {16'b0, rbyte[1], rbyte[0]}
                                        : {{16{rbyte[1][7]}}, rbyte[1], rbyte[0]};
      default: load_data = {rbyte[3], rbyte[2], rbyte[1], rbyte[0]};
    endcase
  end

  // Store: write only the addressed bytes of an accepted, legal store; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !bad) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < nbytes) mem[idx[k]] <= req_wdata[8*k +: 8];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state: a new accept always (re)loads RESP; otherwise a consumed response returns to IDLE.
  always_comb begin
    state_next = state;
    if (accept)                          state_next = RESP;
    else if (state == RESP && rsp_ready) state_next = IDLE;
  end

  // Response payload: loaded on accept, held otherwise; zero data for stores and errors.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_rdata <= 32'b0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_err   <= bad;
      rsp_rdata <= (bad || req_we) ? 32'b0 : load_data;
    end
  end

endmodule

// File: doc/data_memory_hs.md
DATA_MEMORY_HS -- requirements
Module: data_memory_hs

Interface
- REQ-001 SHALL have parameter DEPTH_BYTES, default 1024; memory size in bytes; power of two, minimum 4.
- REQ-002 SHALL have parameter ADDR_W, default 32; width of the request address.
- REQ-003 SHALL have port clk, input, 1; the single clock, all state updates on its rising edge.
- REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-low.
- REQ-005 SHALL have port req_valid, input, 1; a request is presented.
- REQ-006 SHALL have port req_ready, output, 1; the block can accept a request.
- REQ-007 SHALL have port req_we, input, 1; 1 = store, 0 = load.
- REQ-008 SHALL have port req_addr, input, ADDR_W; byte address.
- REQ-009 SHALL have port req_wdata, input, 32; store data, right-aligned.
- REQ-010 SHALL have port req_size, input, 2; 00 = byte, 01 = half, 10 = word, 11 = reserved.
- REQ-011 SHALL have port req_unsigned, input, 1; for loads, 1 = zero-extend, 0 = sign-extend.
- REQ-012 SHALL have port rsp_valid, output, 1; a response is pending.
- REQ-013 SHALL have port rsp_ready, input, 1; the consumer accepts the response.
- REQ-014 SHALL have port rsp_rdata, output, 32; load result, 0 for stores and errors.
- REQ-015 SHALL have port rsp_err, output, 1; the access was rejected.

Function
- REQ-016 SHALL use a two-state FSM: IDLE (no response pending) and RESP (response pending).
- REQ-017 SHALL drive req_ready = !rsp_valid || rsp_ready, so back-to-back accepts sustain one request per cycle.
- REQ-018 SHALL accept a request when req_valid && req_ready; request inputs are sampled only at that edge.
- REQ-019 SHALL set rsp_valid, rsp_rdata and rsp_err on the edge following acceptance (latency 1).
- REQ-020 SHALL hold rsp_valid, rsp_rdata and rsp_err stable while rsp_valid && !rsp_ready.
- REQ-021 SHALL move RESP->IDLE on rsp_ready when no new request is accepted; RESP->RESP with the new response when one is.
- REQ-022 SHALL store little-endian: byte k of the value goes to address addr+k, for k < size bytes; other bytes are untouched.
- REQ-023 SHALL assemble loads little-endian, then sign- or zero-extend byte/half results to 32 bits per req_unsigned.
- REQ-024 SHALL ignore req_unsigned for word loads.
- REQ-025 SHALL set rsp_err=1, perform no write and return rsp_rdata=0 when any of these hold:
  - req_size==11;
  - addr+nbytes-1 >= DEPTH_BYTES (no wrap-around);
  - the access is misaligned (see REQ-031/REQ-032).
- REQ-026 SHALL have a store issue a response with rsp_err=0 and rsp_rdata=0 when it succeeds.
- REQ-027 SHALL make a load accepted the cycle after a store to the same bytes return the newly stored data.

Reset
- REQ-028 SHALL clear rsp_valid, rsp_err and rsp_rdata to 0 and set the FSM to IDLE when rst==0 at a clock edge; req_ready is 1 the cycle after reset.
- REQ-029 SHALL have reset asserted mid-response discard the pending response; requests presented while rst==0 are not accepted and cause no write.
- REQ-030 SHALL leave memory contents unaffected by reset.

Configuration
- REQ-031 SHALL, when macro DMEM_MISALIGN_EN is defined, perform misaligned half/word accesses byte-wise in a single cycle, provided they are in range.
- REQ-032 SHALL, when DMEM_MISALIGN_EN is undefined, reject as errors any half access with addr[0]!=0 and any word access with addr[1:0]!=0.

Verification
- REQ-033 SHALL cover: store word 0xDEADBEEF at 0x10, then load word at 0x10 -> rsp_rdata=0xDEADBEEF one cycle after accept, rsp_err=0.
- REQ-034 SHALL cover: after REQ-033, load byte 0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; load half 0x10 signed -> 0xFFFFBEEF.
- REQ-035 SHALL cover: store byte 0x55 at 0x11 over 0xDEADBEEF, then load word 0x10 -> 0xDEAD55EF.
- REQ-036 SHALL cover: word load at 0x3FE (DEPTH 1024) -> rsp_err=1, rdata=0; word load at 0x12 -> rsp_err=1 without DMEM_MISALIGN_EN, 0xXXXXDEAD-consistent data with it.
- REQ-037 SHALL cover: rsp_ready held 0 for 3 cycles -> req_ready=0 and the response is stable; raising rsp_ready with req_valid high -> the next response appears the following cycle.
- REQ-038 SHALL cover: rst=0 while a store request is held valid and a response is pending -> rsp_valid=0 next cycle and the memory location is unchanged on a later load.
